// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the memory-port arbiter.
//   arb_state_e     : arbiter FSM states
//   owner_e         : which requester owns the outstanding access
//   TIMEOUT_DEFAULT : default wait limit, in cycles, for mem_rdy
//   WAIT_CW         : wait-counter width (covers TIMEOUT range 1..255)
package riscv_mem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int unsigned TIMEOUT_DEFAULT = 15;
  localparam int unsigned WAIT_CW         = 8;

endpackage

// File: rtl/arb_wait_counter.sv
// Wait counter for an outstanding memory access.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : clear (asserted on entry into BUSY)
//   en_i       : count one BUSY cycle that had no mem_rdy
//   tc_o       : the current cycle is the TIMEOUT-th wait cycle; if mem_rdy
//                is still low now, the access times out at the next edge
module arb_wait_counter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [WAIT_CW-1:0] TC_VAL = WAIT_CW'(TIMEOUT - 1);

  logic [WAIT_CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WAIT_CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one memory port,
// one access outstanding at a time.
//   if_*  : fetch read requester (req/addr in; gnt/rvalid/err/rdata out)
//   ls_*  : load/store requester (req/we/be/addr/wdata in; gnt/rvalid/err/rdata out)
//   mem_* : shared memory port (req/we/be/addr/wdata out; rdy/rdata in)
// Optional build macro ARB_ROUND_ROBIN_EN: on simultaneous requests, grant
// the requester that was not granted last. Undefined: load/store always wins.
//
// state   | meaning
// IDLE    | no access outstanding; grant a requester combinationally
// BUSY    | mem_req held with latched fields until mem_rdy or timeout
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic            if_err_o,
  output logic [DW-1:0]   if_rdata_o,
  input  logic            ls_req_i,
  input  logic            ls_we_i,
  input  logic [DW/8-1:0] ls_be_i,
  input  logic [AW-1:0]   ls_addr_i,
  input  logic [DW-1:0]   ls_wdata_i,
  output logic            ls_gnt_o,
  output logic            ls_rvalid_o,
  output logic            ls_err_o,
  output logic [DW-1:0]   ls_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic            mem_rdy_i,
  input  logic [DW-1:0]   mem_rdata_i
);

  arb_state_e      state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [DW/8-1:0] be_q, be_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            rvalid_q, rvalid_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic busy, pick_ls, if_gnt_c, ls_gnt_c, cnt_clr, tc;

  assign busy = (state_q == ST_BUSY);

  // owner_q doubles as "last granted" since it only changes on a grant.
`ifdef ARB_ROUND_ROBIN_EN
  assign pick_ls = ls_req_i && (!if_req_i || (owner_q == OWN_IF));
`else
  assign pick_ls = ls_req_i;
`endif

  arb_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (busy && !mem_rdy_i),
    .tc_o  (tc)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    if_gnt_c = 1'b0;
    ls_gnt_c = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (if_req_i || ls_req_i) begin
          state_d = ST_BUSY;
          cnt_clr = 1'b1;
          if (pick_ls) begin
            ls_gnt_c = 1'b1;
            owner_d  = OWN_LS;
            addr_d   = ls_addr_i;
            we_d     = ls_we_i;
            be_d     = ls_be_i;
            wdata_d  = ls_wdata_i;
          end else begin
            if_gnt_c = 1'b1;
            owner_d  = OWN_IF;
            addr_d   = if_addr_i;
            we_d     = 1'b0;
            be_d     = '1;
            wdata_d  = '0;
          end
        end
      end
      ST_BUSY: begin
        if (mem_rdy_i) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b1;
          rdata_d  = we_q ? '0 : mem_rdata_i;
        end else if (tc) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_IF;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Grants are combinational from the requests, so gate them with reset to
  // keep every output low while rst_n is asserted.
  assign if_gnt_o = rst_n && if_gnt_c;
  assign ls_gnt_o = rst_n && ls_gnt_c;

  // owner_q still names the finished access in the response cycle: a grant
  // made in that same cycle only updates it at the following edge.
  assign if_rvalid_o = rvalid_q && (owner_q == OWN_IF);
  assign if_err_o    = err_q && (owner_q == OWN_IF);
  assign if_rdata_o  = (owner_q == OWN_IF) ? rdata_q : '0;
  assign ls_rvalid_o = rvalid_q && (owner_q == OWN_LS);
  assign ls_err_o    = err_q && (owner_q == OWN_LS);
  assign ls_rdata_o  = (owner_q == OWN_LS) ? rdata_q : '0;

  assign mem_req_o   = busy;
  assign mem_we_o    = busy && we_q;
  assign mem_be_o    = busy ? be_q : '0;
  assign mem_addr_o  = busy ? addr_q : '0;
  assign mem_wdata_o = busy ? wdata_q : '0;

endmodule
